fir_transpose_param: RTL and testbench

//  Parametrised transposed-form FIR filter: the successor to the fixed 33-tap

---
 rtl/fir_transpose_param_if.sv | 32 +++
 rtl/fir_transpose_param.sv | 91 +++++++++
 tb/tb_fir_transpose_param.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fir_transpose_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_transpose_param_if
//  Brief    : Sample, coefficient-write and output bus of the transposed FIR.
//  Revision : 1.0 - initial release
// ============================================================================
interface fir_transpose_param_if #(
    parameter int TAPS = 33,
    parameter int XW   = 15,
    parameter int HW   = 16,
    parameter int YW   = 19,
    parameter int AW   = $clog2(TAPS)
);
    logic          In_Valid;
    logic [XW-1:0] X;
    logic          Coef_We;
    logic [AW-1:0] Coef_Addr;
    logic [HW-1:0] Coef_Data;
    logic          Out_Valid;
    logic [YW-1:0] Y;

    modport master (
        output In_Valid, X, Coef_We, Coef_Addr, Coef_Data,
        input  Out_Valid, Y
    );

    modport slave (
        input  In_Valid, X, Coef_We, Coef_Addr, Coef_Data,
        output Out_Valid, Y
    );
endinterface
`default_nettype wire

// File: rtl/fir_transpose_param.sv
`default_nettype none
// ============================================================================
//  Module   : fir_transpose_param
//  Brief    : Parametrised transposed-form FIR with host-writable coefficients
//             and a sample-valid enable. Optional macro FIR_SAT_EN makes every
//             adder saturate instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_transpose_param #(
    parameter int TAPS  = 33,
    parameter int XW    = 15,
    parameter int HW    = 16,
    parameter int SHIFT = 13,
    parameter int PW    = 16,
    parameter int YW    = 19
) (
    input  logic                    Clk,
    input  logic                    Reset,
    fir_transpose_param_if.slave    bus
);
    localparam int                      c_AW   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [c_AW:0]           c_TAPS = (c_AW + 1)'(TAPS);
    localparam logic signed [YW-1:0]    c_YMAX = {1'b0, {(YW-1){1'b1}}};
    localparam logic signed [YW-1:0]    c_YMIN = {1'b1, {(YW-1){1'b0}}};

    // Reduce a YW+1-bit adder result back to YW bits.
    function automatic logic signed [YW-1:0] f_fold(input logic signed [YW:0] s);
`ifdef FIR_SAT_EN
        if (s[YW] != s[YW-1]) begin
            return s[YW] ? c_YMIN : c_YMAX;
        end
`endif
        return YW'(s);
    endfunction

    logic signed [HW-1:0] r_h      [TAPS];
    logic signed [YW-1:0] w_p      [TAPS];
    logic signed [YW-1:0] r_z      [TAPS-1];
    logic signed [YW-1:0] w_z_next [TAPS-1];
    logic signed [YW-1:0] w_y_next;
    logic signed [YW-1:0] r_y;
    logic                 r_out_valid;
    logic                 w_coef_hit;

    generate
        for (genvar k = 0; k < TAPS; k++) begin : g_prod
            logic signed [XW+HW-1:0] w_full;
            logic signed [PW-1:0]    w_trunc;
            assign w_full  = $signed(bus.X) * r_h[k];
            assign w_trunc = PW'(w_full >>> SHIFT);
            assign w_p[k]  = YW'(w_trunc);
        end

        for (genvar k = 0; k < TAPS - 2; k++) begin : g_chain
            assign w_z_next[k] = f_fold((YW+1)'(w_p[k+1]) + (YW+1)'(r_z[k+1]));
        end
    endgenerate

    assign w_z_next[TAPS-2] = w_p[TAPS-1];
    assign w_y_next         = f_fold((YW+1)'(w_p[0]) + (YW+1)'(r_z[0]));
    assign w_coef_hit       = bus.Coef_We && ({1'b0, bus.Coef_Addr} < c_TAPS);

    // Coefficient updates land after this edge, so a coincident sample sees the old H.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_h[k] <= '0;
            end
            for (int k = 0; k < TAPS - 1; k++) begin
                r_z[k] <= '0;
            end
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (bus.In_Valid) begin
                for (int k = 0; k < TAPS - 1; k++) begin
                    r_z[k] <= w_z_next[k];
                end
                r_y <= w_y_next;
            end
            r_out_valid <= bus.In_Valid;
            if (w_coef_hit) begin
                r_h[bus.Coef_Addr] <= $signed(bus.Coef_Data);
            end
        end
    end

    assign bus.Y         = r_y;
    assign bus.Out_Valid = r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_fir_transpose_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_transpose_param
//  Brief    : Directed and random checks of fir_transpose_param against a
//             convolution model built from a per-sample product history.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_transpose_param;
    localparam int TAPS  = 33;
    localparam int XW    = 15;
    localparam int HW    = 16;
    localparam int SHIFT = 13;
    localparam int PW    = 16;
    localparam int YW    = 19;
    localparam int AW    = $clog2(TAPS);

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    fir_transpose_param_if #(.TAPS(TAPS), .XW(XW), .HW(HW), .YW(YW), .AW(AW)) bus ();

    fir_transpose_param #(
        .TAPS(TAPS), .XW(XW), .HW(HW), .SHIFT(SHIFT), .PW(PW), .YW(YW)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference state: live coefficients and the products each accepted sample
    // produced (row = sample age, column = tap), captured with H at accept time.
    int  h_m [TAPS];
    int  ph  [TAPS][TAPS];
    int  y_m;
    bit  ov_m;

    function automatic longint f_wrap(input longint v, input int w);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
        return m;
    endfunction

    function automatic int f_prod(input int x, input int h);
        longint pr;
        pr = (longint'(x) * longint'(h)) >>> SHIFT;
        return int'(f_wrap(pr, PW));
    endfunction

    function automatic int f_add(input longint v);
`ifdef FIR_SAT_EN
        if (v > (longint'(1) << (YW - 1)) - 1) return (1 << (YW - 1)) - 1;
        if (v < -(longint'(1) << (YW - 1)))    return -(1 << (YW - 1));
        return int'(v);
`else
        return int'(f_wrap(v, YW));
`endif
    endfunction

    function automatic int f_ramp(input int i);
        int n;
        n = (i < TAPS) ? i : TAPS;
        return f_add(longint'(n) * 16384);
    endfunction

    task automatic model_edge(input bit rst, input bit vld, input logic [XW-1:0] x,
                              input bit we, input logic [AW-1:0] addr, input logic [HW-1:0] d);
        longint acc;
        if (rst) begin
            foreach (h_m[k]) h_m[k] = 0;
            foreach (ph[a, k]) ph[a][k] = 0;
            y_m  = 0;
            ov_m = 1'b0;
        end else begin
            if (vld) begin
                for (int a = TAPS - 1; a > 0; a--)
                    for (int k = 0; k < TAPS; k++) ph[a][k] = ph[a-1][k];
                for (int k = 0; k < TAPS; k++) ph[0][k] = f_prod(int'($signed(x)), h_m[k]);
                // Y(n) = P0(n) + (P1(n-1) + (P2(n-2) + ...)), each sum reduced to YW bits.
                acc = ph[TAPS-1][TAPS-1];
                for (int k = TAPS - 2; k >= 0; k--) acc = f_add(ph[k][k] + acc);
                y_m = int'(acc);
            end
            ov_m = vld;
            if (we && int'(addr) < TAPS) h_m[addr] = int'($signed(d));
        end
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit vld, input logic [XW-1:0] x,
                        input bit we, input logic [AW-1:0] addr, input logic [HW-1:0] d,
                        output logic signed [31:0] y_obs);
        Reset         = rst;
        bus.In_Valid  = vld;
        bus.X         = x;
        bus.Coef_We   = we;
        bus.Coef_Addr = addr;
        bus.Coef_Data = d;
        @(posedge Clk);
        model_edge(rst, vld, x, we, addr, d);
        #1;
        chk("out_valid", 32'(bus.Out_Valid), 32'(ov_m));
        chk("y", 32'($signed(bus.Y)), y_m);
        y_obs = 32'($signed(bus.Y));
    endtask

    initial begin
        logic signed [31:0] y;
        logic [XW-1:0]      rx;
        logic [HW-1:0]      rd;
        bus.In_Valid  = 1'b0;
        bus.X         = '0;
        bus.Coef_We   = 1'b0;
        bus.Coef_Addr = '0;
        bus.Coef_Data = '0;
        foreach (h_m[k]) h_m[k] = 0;
        foreach (ph[a, k]) ph[a][k] = 0;
        y_m  = 0;
        ov_m = 1'b0;

        // Reset wins over a valid full-scale sample.
        step(1, 1, 15'h7FFF, 0, '0, '0, y);
        chk("reset_y", y, 0);
        chk("reset_ov", 32'(bus.Out_Valid), 0);

        // Impulse: H=4000h everywhere, X=2000h -> P=16384 on each tap in turn.
        for (int k = 0; k < TAPS; k++) step(0, 0, '0, 1, AW'(k), 16'h4000, y);
        step(0, 1, 15'h2000, 0, '0, '0, y);
        chk("impulse_first", y, 16384);
        for (int i = 1; i < TAPS; i++) begin
            step(0, 1, '0, 0, '0, '0, y);
            chk("impulse_tail", y, 16384);
        end
        step(0, 1, '0, 0, '0, '0, y);
        chk("impulse_done", y, 0);

        // Step input ramps by 16384 per sample until the window is full.
        for (int i = 1; i <= TAPS + 4; i++) begin
            step(0, 1, 15'h2000, 0, '0, '0, y);
            chk("ramp", y, f_ramp(i));
        end

        // Impulse with gap cycles; gaps must hold Y and drop Out_Valid.
        for (int i = 0; i < TAPS; i++) step(0, 1, '0, 0, '0, '0, y);
        step(0, 1, 15'h2000, 0, '0, '0, y);
        for (int i = 0; i < 3 * TAPS; i++) begin
            step(0, (i % 3) == 2, '0, 0, '0, '0, y);
            if ((i % 3) != 2) chk("gap_hold", y, 16384);
        end

        // Coefficient write coincident with a sample, then an out-of-range write.
        for (int i = 0; i < TAPS; i++) step(0, 1, '0, 0, '0, '0, y);
        step(0, 1, 15'h2000, 1, AW'(0), 16'h2000, y);
        chk("coef_old_h", y, 16384);
        step(0, 1, 15'h2000, 0, '0, '0, y);
        chk("coef_new_h", y, 8192 + 16384);
        step(0, 0, '0, 1, AW'(TAPS), 16'h7FFF, y);
        step(0, 1, '0, 0, '0, '0, y);
        chk("coef_oob", y, 32768);

        // Mid-ramp reset clears history and coefficients.
        for (int i = 0; i < 5; i++) step(0, 1, 15'h2000, 0, '0, '0, y);
        step(1, 1, 15'h2000, 0, '0, '0, y);
        chk("midreset_y", y, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 15'h2000, 0, '0, '0, y);
            chk("after_reset", y, 0);
        end

        // Random coefficients, samples, writes and the occasional reset.
        for (int k = 0; k < TAPS; k++) begin
            rd = HW'($urandom);
            step(0, 0, '0, 1, AW'(k), rd, y);
        end
        for (int i = 0; i < 600; i++) begin
            rx = XW'($urandom);
            rd = HW'($urandom);
            step($urandom_range(0, 249) == 0, $urandom_range(0, 3) != 0, rx,
                 $urandom_range(0, 7) == 0, AW'($urandom_range(0, 63)), rd, y);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
